tmp_alarm_monitor: RTL and testbench
====================================

# tmp_alarm_monitor

Multi-channel temperature supervisor between the I2C read path (`tmp_change` output) and the VGA `imageGenerator`. Each integer-°C sample is tagged with a channel. The block block-averages samples per channel and classifies each channel as NORMAL, WARN or FIRE with hysteresis. It keeps a sticky fire alarm with acknowledge, and sequentially converts a selected channel's average to BCD for on-screen digits.

## Interface
- `CHANNELS`, 3: number of sensor channels (1..8).
- `DATA_W`, 8: sample width, unsigned °C.
- `AVG_LOG2`, 2: average over 2^AVG_LOG2 samples (0 = no averaging).
- `WARN_TH`, 50: warning threshold, °C.
- `FIRE_TH`, 70: fire threshold, °C (> WARN_TH).
- `HYST`, 3: clear hysteresis, °C.
- `BCD_DIGITS`, 3: BCD output digits (must cover 2^DATA_W−1).

Ports:
- `clk` in 1: system clock. One clock domain only.
- `rst_n` in 1: reset, synchronous and active-low.
- `sample_valid` in 1: one-cycle strobe, sample present.
- `sample_ch` in CH_W = max(1, clog2(CHANNELS)): channel tag.
- `sample_data` in DATA_W: temperature sample.
- `sel_ch` in CH_W: channel shown in BCD.
- `ack` in 1: clears sticky fire alarm.
- `is_warning` out CHANNELS: channel in WARN or FIRE.
- `is_fire` out CHANNELS: channel in FIRE.
- `fire_latched` out 1: sticky fire alarm.
- `avg_out` out DATA_W: current average of `sel_ch`.
- `bcd` out 4*BCD_DIGITS: BCD of `avg_out`, most significant digit highest.
- `bcd_valid` out 1: one-cycle pulse when `bcd` updates.

## Operation
- Sample acceptance:
  - A sample is accepted on any edge with `sample_valid`=1.
  - If `sample_ch` ≥ CHANNELS, the sample is dropped with no state change.
- Per-channel state:
  - Accumulator of DATA_W+AVG_LOG2 bits and a count.
  - On the 2^AVG_LOG2-th sample, `avg[ch]` = (acc + sample) >> AVG_LOG2, truncated. The accumulator and count then clear.
- Per-channel FSM, evaluated once per new average:
  - NORMAL: avg ≥ FIRE_TH → FIRE; else avg ≥ WARN_TH → WARN.
  - WARN: avg ≥ FIRE_TH → FIRE; avg < WARN_TH−HYST → NORMAL; otherwise stay.
  - FIRE: if avg < FIRE_TH−HYST, go to WARN when avg ≥ WARN_TH−HYST, else NORMAL. Otherwise stay.
  - Threshold−HYST saturates at 0.
- `fire_latched`:
  - Set when any channel enters FIRE.
  - `ack` clears it only if no channel is currently in FIRE; otherwise `ack` is ignored.
  - Set and `ack` on the same edge: set wins.
- BCD conversion:
  - Double-dabble over DATA_W iterations, one iteration per cycle.
  - Triggered when `avg[sel_ch]` updates or `sel_ch` changes.
  - A trigger while busy sets a pending flag. The conversion restarts once the current one finishes, so at most one restart is queued.
  - `bcd` holds its old value until done.
- Reset: all accumulators, counts, averages, `bcd` and `fire_latched` go to 0. All FSMs go to NORMAL. The converter goes idle and the pending flag clears. A partial average in flight is discarded.

## Timing
- Reset values: `is_warning`=0, `is_fire`=0, `fire_latched`=0, `avg_out`=0, `bcd`=0, `bcd_valid`=0.
- Final sample accepted at edge E:
  - `avg[ch]` updates at E.
  - `is_warning`/`is_fire` update at E+1.
  - `fire_latched` sets at E+2.
- `avg_out` is combinational from registered `avg[sel_ch]`.
- Conversion starts the edge after the trigger. `bcd` and `bcd_valid` update DATA_W+1 edges later.
- `sample_valid` may be high every cycle, including on different channels back to back. Each channel's update path is independent, and samples are never stalled.

## Structure
- Shared package `tmp_pkg`:
  - state enum {NORMAL, WARN, FIRE};
  - default threshold constants.
- Sub-module `bcd_seq`: start/busy/done interface, parameters DATA_W and BCD_DIGITS. The pending logic stays in the parent.

## Test plan
- Channel 0, samples 48, 50, 52, 54, `sel_ch`=0 → avg 51, `is_warning[0]`=1 two edges after the last sample, `bcd`=0x051 with one `bcd_valid` pulse.
- Channel 0 in WARN:
  - 4×48 → avg 48 ≥ 47, stays WARN;
  - then 4×46 → NORMAL, `is_warning[0]`=0.
- Fire and acknowledge on channel 1:
  - 4×80 → FIRE, `fire_latched`=1;
  - `ack` while still FIRE → stays 1;
  - 4×60 → WARN (60 < 67, ≥ 47);
  - `ack` → `fire_latched`=0;
  - `ack` asserted on the same edge as a new FIRE entry → stays 1.
- `sample_ch`=3 with data 99 → dropped. No change to any channel state or output.
- Reset mid-operation:
  - 2 samples of 90 on channel 2, then `rst_n`=0 for one edge;
  - then 4×20 → avg 20, NORMAL (no mixing with the discarded samples).
- BCD pending and `sel_ch` switch:
  - channel 0 avg 255 → `bcd`=0x255;
  - switch `sel_ch` mid-conversion → current conversion finishes, then exactly one restart shows the new channel.

Source files
------------

// File: rtl/tmp_pkg.sv
// Shared types and defaults for the temperature alarm monitor.
// Holds the channel state encoding and the hysteresis next-state rule.
package tmp_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        WARN   = 2'd1,
        FIRE   = 2'd2
    } state_t;

    localparam int WARN_TH_DEF = 50;
    localparam int FIRE_TH_DEF = 70;
    localparam int HYST_DEF    = 3;

    function automatic int sat_sub(int a, int b);
        return (a > b) ? a - b : 0;
    endfunction

    function automatic state_t next_state(
        state_t cur,
        int     avg,
        int     warn_th,
        int     fire_th,
        int     hyst
    );
        state_t nxt;
        int     warn_lo;
        int     fire_lo;
        nxt     = cur;
        warn_lo = sat_sub(warn_th, hyst);
        fire_lo = sat_sub(fire_th, hyst);
        case (cur)
            NORMAL: begin
                if (avg >= fire_th)
                    nxt = FIRE;
                else if (avg >= warn_th)
                    nxt = WARN;
            end
            WARN: begin
                if (avg >= fire_th)
                    nxt = FIRE;
                else if (avg < warn_lo)
                    nxt = NORMAL;
            end
            FIRE: begin
                if (avg < fire_lo)
                    nxt = (avg >= warn_lo) ? WARN : NORMAL;
            end
            default: nxt = NORMAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
// One shift per cycle; the result register only changes on completion.
module bcd_seq #(
    parameter int DATA_W     = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       value,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int BW = 4 * BCD_DIGITS;
    localparam int IW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] bin_q;
    logic [BW-1:0]     work_q;
    logic [BW-1:0]     adj;
    logic [IW-1:0]     iter_q;

    always_comb begin
        adj = work_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (work_q[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            bcd    <= '0;
            bin_q  <= '0;
            work_q <= '0;
            iter_q <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy   <= 1'b1;
                    bin_q  <= value;
                    work_q <= '0;
                    iter_q <= IW'(DATA_W);
                end
            end else if (iter_q != '0) begin
                work_q <= {adj[BW-2:0], bin_q[DATA_W-1]};
                bin_q  <= bin_q << 1;
                iter_q <= iter_q - 1'b1;
            end else begin
                bcd  <= work_q;
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tmp_alarm_monitor.sv
// Multi-channel temperature supervisor: block averaging, hysteretic
// NORMAL/WARN/FIRE classification, sticky fire alarm and BCD readout.
module tmp_alarm_monitor
    import tmp_pkg::*;
#(
    parameter int  CHANNELS   = 3,
    parameter int  DATA_W     = 8,
    parameter int  AVG_LOG2   = 2,
    parameter int  WARN_TH    = WARN_TH_DEF,
    parameter int  FIRE_TH    = FIRE_TH_DEF,
    parameter int  HYST       = HYST_DEF,
    parameter int  BCD_DIGITS = 3,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_valid,
    input  logic [CH_W-1:0]         sample_ch,
    input  logic [DATA_W-1:0]       sample_data,
    input  logic [CH_W-1:0]         sel_ch,
    input  logic                    ack,
    output logic [CHANNELS-1:0]     is_warning,
    output logic [CHANNELS-1:0]     is_fire,
    output logic                    fire_latched,
    output logic [DATA_W-1:0]       avg_out,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    bcd_valid
);

    localparam int AW   = DATA_W + AVG_LOG2;
    localparam int CW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int NSEL = 1 << CH_W;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0]     acc_q  [CHANNELS];
    logic [AW-1:0]     sum    [CHANNELS];
    logic [CW-1:0]     cnt_q  [CHANNELS];
    logic [DATA_W-1:0] avg_q  [CHANNELS];
    state_t            st_q   [CHANNELS];
    state_t            st_nxt [CHANNELS];
    logic [CHANNELS-1:0] upd_q;
    logic              fire_enter;
    logic              fire_enter_q;

    logic [DATA_W-1:0] avg_pad [NSEL];
    logic [NSEL-1:0]   upd_pad;
    logic [CH_W-1:0]   sel_q;
    logic              pend_q;
    logic              trig;
    logic              start;
    logic              busy;

    always_comb begin
        fire_enter = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            sum[i]    = acc_q[i] + AW'(sample_data);
            st_nxt[i] = upd_q[i]
                ? next_state(st_q[i], int'(avg_q[i]),
                             WARN_TH, FIRE_TH, HYST)
                : st_q[i];
            if (st_nxt[i] == FIRE && st_q[i] != FIRE)
                fire_enter = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
                avg_q[i] <= '0;
                st_q[i]  <= NORMAL;
            end
            upd_q        <= '0;
            is_warning   <= '0;
            is_fire      <= '0;
            fire_enter_q <= 1'b0;
        end else begin
            fire_enter_q <= fire_enter;
            for (int i = 0; i < CHANNELS; i++) begin
                upd_q[i]      <= 1'b0;
                st_q[i]       <= st_nxt[i];
                is_warning[i] <= (st_nxt[i] != NORMAL);
                is_fire[i]    <= (st_nxt[i] == FIRE);
                if (sample_valid && int'(sample_ch) == i) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        avg_q[i] <= DATA_W'(sum[i] >> AVG_LOG2);
                        acc_q[i] <= '0;
                        cnt_q[i] <= '0;
                        upd_q[i] <= 1'b1;
                    end else begin
                        acc_q[i] <= sum[i];
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // A fresh fire entry beats a simultaneous acknowledge.
    always_ff @(posedge clk) begin
        if (!rst_n)
            fire_latched <= 1'b0;
        else if (fire_enter_q)
            fire_latched <= 1'b1;
        else if (ack && is_fire == '0)
            fire_latched <= 1'b0;
    end

    always_comb begin
        for (int i = 0; i < NSEL; i++) begin
            avg_pad[i] = '0;
            upd_pad[i] = 1'b0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            avg_pad[i] = avg_q[i];
            upd_pad[i] = upd_q[i];
        end
    end

    assign avg_out = avg_pad[sel_ch];
    assign trig    = upd_pad[sel_ch] | (sel_ch != sel_q);
    assign start   = !busy && (trig || pend_q);

    // Triggers during a conversion collapse into one queued restart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            sel_q <= sel_ch;
            if (start)
                pend_q <= 1'b0;
            else if (trig)
                pend_q <= 1'b1;
        end
    end

    bcd_seq #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .value (avg_out),
        .busy  (busy),
        .done  (bcd_valid),
        .bcd   (bcd)
    );

endmodule

// File: tb/tb_tmp_alarm_monitor.sv
// Directed bench for tmp_alarm_monitor with a BCD result scoreboard.
// Expected BCD values are queued at stimulus time and popped on bcd_valid.
module tb_tmp_alarm_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [7:0]  sample_data;
    logic [1:0]  sel_ch;
    logic        ack;
    logic [2:0]  is_warning;
    logic [2:0]  is_fire;
    logic        fire_latched;
    logic [7:0]  avg_out;
    logic [11:0] bcd;
    logic        bcd_valid;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    tmp_alarm_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .sel_ch       (sel_ch),
        .ack          (ack),
        .is_warning   (is_warning),
        .is_fire      (is_fire),
        .fire_latched (fire_latched),
        .avg_out      (avg_out),
        .bcd          (bcd),
        .bcd_valid    (bcd_valid)
    );

    function automatic logic [11:0] to_bcd(int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(int ch, int d);
        sample_ch    = 2'(ch);
        sample_data  = 8'(d);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic send4(int ch, int d);
        repeat (4) send(ch, d);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bcd_valid === 1'b1) begin
            if (exp_q.size() == 0)
                chk("bcd_unexpected_pulse", 32'(bcd_valid), 32'd0);
            else
                chk("bcd_scoreboard", 32'(bcd), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_ch    = '0;
        sample_data  = '0;
        sel_ch       = '0;
        ack          = 1'b0;
        tick(2);
        rst_n = 1'b1;
        chk("rst_is_warning", 32'(is_warning), 32'd0);
        chk("rst_is_fire", 32'(is_fire), 32'd0);
        chk("rst_fire_latched", 32'(fire_latched), 32'd0);
        chk("rst_avg_out", 32'(avg_out), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_bcd_valid", 32'(bcd_valid), 32'd0);

        // Channel 0 average 51 -> WARN, BCD 051
        exp_q.push_back(to_bcd(51));
        send(0, 48);
        send(0, 50);
        send(0, 52);
        send(0, 54);
        chk("avg51_avg_out", 32'(avg_out), 32'd51);
        chk("avg51_warn_not_yet", 32'(is_warning), 32'd0);
        tick();
        chk("avg51_is_warning", 32'(is_warning), 32'b001);
        chk("avg51_is_fire", 32'(is_fire), 32'd0);
        tick(8);
        chk("avg51_bcd_valid_early", 32'(bcd_valid), 32'd0);
        tick();
        chk("avg51_bcd_valid", 32'(bcd_valid), 32'd1);
        chk("avg51_bcd", 32'(bcd), 32'h051);
        tick();
        chk("avg51_bcd_valid_pulse", 32'(bcd_valid), 32'd0);
        tick(2);

        // WARN hysteresis on channel 0
        exp_q.push_back(to_bcd(48));
        send4(0, 48);
        tick();
        chk("hyst48_stays_warn", 32'(is_warning), 32'b001);
        tick(12);
        exp_q.push_back(to_bcd(46));
        send4(0, 46);
        tick();
        chk("hyst46_normal", 32'(is_warning), 32'd0);
        tick(12);

        // Fire and acknowledge on channel 1
        send4(1, 80);
        tick();
        chk("fire_is_fire", 32'(is_fire), 32'b010);
        chk("fire_is_warning", 32'(is_warning), 32'b010);
        chk("fire_latch_not_yet", 32'(fire_latched), 32'd0);
        tick();
        chk("fire_latched_set", 32'(fire_latched), 32'd1);
        pulse_ack();
        chk("ack_during_fire", 32'(fire_latched), 32'd1);
        send4(1, 60);
        tick();
        chk("fire_to_warn_is_fire", 32'(is_fire), 32'd0);
        chk("fire_to_warn_is_warning", 32'(is_warning), 32'b010);
        chk("fire_to_warn_latched", 32'(fire_latched), 32'd1);
        pulse_ack();
        chk("ack_clears", 32'(fire_latched), 32'd0);
        send4(1, 80);
        ack = 1'b1;
        tick(2);
        ack = 1'b0;
        chk("ack_vs_set", 32'(fire_latched), 32'd1);
        chk("refire_is_fire", 32'(is_fire), 32'b010);
        send4(1, 60);
        tick();
        pulse_ack();
        chk("ack_clears_again", 32'(fire_latched), 32'd0);

        // Out-of-range channel is dropped
        send(3, 99);
        tick(3);
        chk("drop_is_warning", 32'(is_warning), 32'b010);
        chk("drop_is_fire", 32'(is_fire), 32'd0);
        chk("drop_avg_out", 32'(avg_out), 32'd46);
        chk("drop_fire_latched", 32'(fire_latched), 32'd0);

        // Reset with a partial average in flight on channel 2
        send(2, 90);
        send(2, 90);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_is_warning", 32'(is_warning), 32'd0);
        chk("mid_rst_avg_out", 32'(avg_out), 32'd0);
        chk("mid_rst_bcd", 32'(bcd), 32'd0);
        exp_q.push_back(to_bcd(0));
        sel_ch = 2'd2;
        tick(12);
        exp_q.push_back(to_bcd(20));
        send4(2, 20);
        chk("post_rst_avg20", 32'(avg_out), 32'd20);
        tick();
        chk("post_rst_normal", 32'(is_warning), 32'd0);
        tick(12);
        chk("post_rst_bcd", 32'(bcd), 32'h020);

        // Pending restart after a sel_ch switch mid-conversion
        send4(1, 33);
        tick(2);
        exp_q.push_back(to_bcd(0));
        sel_ch = 2'd0;
        tick(12);
        exp_q.push_back(to_bcd(255));
        send4(0, 255);
        chk("avg255_avg_out", 32'(avg_out), 32'd255);
        tick(3);
        exp_q.push_back(to_bcd(33));
        sel_ch = 2'd1;
        tick(25);
        chk("pend_bcd", 32'(bcd), 32'h033);
        chk("pend_avg_out", 32'(avg_out), 32'd33);
        chk("avg255_is_fire", 32'(is_fire), 32'b001);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
